lane_deskew: RTL and testbench

LANE_DESKEW -- requirements
Module: lane_deskew

---
 rtl/mipi_pkg.sv | 17 +
 rtl/lane_delay_line.sv | 52 +++++
 rtl/lane_deskew.sv | 141 ++++++++++++++
 tb/tb_lane_deskew.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mipi_pkg.sv
// Shared definitions for the MIPI lane deskew block.
package mipi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  // Width of one per-lane offset field.
  localparam int unsigned OFFSET_W = 3;

  // Largest supported arrival spread, in byte-clock cycles.
  localparam int unsigned MAX_SKEW_LIMIT = 7;

endpackage

// File: rtl/lane_delay_line.sv
// Per-lane byte delay line with a selectable tap.
// Tap 0 is the live input and tap k is the input from k cycles ago, so
// DEPTH = MAX_SKEW+1 taps cover every legal offset.
module lane_delay_line
  import mipi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          i_data,
  input  logic [OFFSET_W-1:0] i_tap,
  output logic [7:0]          o_data
);

  logic [7:0] w_taps [DEPTH];

  assign w_taps[0] = i_data;

  if (DEPTH > 1) begin : g_sr
    logic [7:0] r_sr [DEPTH-1];

    // Shift register holding the previous DEPTH-1 input bytes.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int unsigned k = 0; k < DEPTH - 1; k++) begin
          r_sr[k] <= '0;
        end
      end else begin
        r_sr[0] <= i_data;
        for (int unsigned k = 1; k < DEPTH - 1; k++) begin
          r_sr[k] <= r_sr[k-1];
        end
      end
    end

    for (genvar t = 1; t < DEPTH; t++) begin : g_tap
      assign w_taps[t] = r_sr[t-1];
    end
  end

  // Tap select; an out-of-range tap yields zero.
  always_comb begin
    o_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (i_tap == OFFSET_W'(k)) begin
        o_data = w_taps[k];
      end
    end
  end

endmodule

// File: rtl/lane_deskew.sv
// Multi-lane first-byte deskew: measures per-lane arrival spread at burst
// start, locks per-lane delays, and emits aligned words until packet_done.
module lane_deskew
  import mipi_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned MAX_SKEW  = 3
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [8*NUM_LANES-1:0]        lane_byte_data,
  input  logic [NUM_LANES-1:0]          lane_byte_vld,
  input  logic                          packet_done,
  output logic [8*NUM_LANES-1:0]        word_data,
  output logic                          word_vld,
  output logic                          invalid_start,
  output logic [OFFSET_W*NUM_LANES-1:0] lane_offset
);

  localparam int unsigned     CNT_W    = OFFSET_W + 1;
  localparam logic [CNT_W-1:0] SKEW_MAX = CNT_W'(MAX_SKEW);

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [NUM_LANES-1:0]          r_arrived;
  logic [OFFSET_W*NUM_LANES-1:0] r_arr_cnt;
  logic [OFFSET_W*NUM_LANES-1:0] r_offset;
  logic                          r_word_vld;
  logic                          r_invalid;
  logic [8*NUM_LANES-1:0]        r_word;

  logic                          w_in_align;
  logic [CNT_W-1:0]              w_cnt_now;
  logic [NUM_LANES-1:0]          w_prev_arr;
  logic [NUM_LANES-1:0]          w_arr_now;
  logic                          w_lock;
  logic                          w_fail;
  logic [OFFSET_W*NUM_LANES-1:0] w_arr_cnt;
  logic [OFFSET_W*NUM_LANES-1:0] w_new_off;
  logic [OFFSET_W*NUM_LANES-1:0] w_tap;
  logic [8*NUM_LANES-1:0]        w_lane_out;

  // Arrival bookkeeping for the current edge. The lock offsets are steered
  // to the delay lines combinationally so the first aligned word is
  // registered on the same edge that samples the last lane.
  always_comb begin
    w_in_align = ((r_state == ST_IDLE) && (|lane_byte_vld)) || (r_state == ST_ALIGN);
    w_cnt_now  = (r_state == ST_ALIGN) ? (r_cnt + CNT_W'(1)) : '0;
    w_prev_arr = (r_state == ST_ALIGN) ? r_arrived : '0;
    w_arr_now  = w_prev_arr | lane_byte_vld;
    w_lock     = w_in_align && (&w_arr_now) && (w_cnt_now <= SKEW_MAX);
    w_fail     = (r_state == ST_ALIGN) && (w_cnt_now > SKEW_MAX);
    w_arr_cnt  = '0;
    w_new_off  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      w_arr_cnt[i*OFFSET_W +: OFFSET_W] = w_prev_arr[i] ? r_arr_cnt[i*OFFSET_W +: OFFSET_W]
                                                        : w_cnt_now[OFFSET_W-1:0];
      w_new_off[i*OFFSET_W +: OFFSET_W] = w_cnt_now[OFFSET_W-1:0]
                                          - w_arr_cnt[i*OFFSET_W +: OFFSET_W];
    end
    w_tap = w_lock ? w_new_off : r_offset;
  end

  // Burst FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_arrived  <= '0;
      r_arr_cnt  <= '0;
      r_offset   <= '0;
      r_word_vld <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      r_invalid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ALIGN: begin
          if (w_in_align) begin
            r_cnt     <= w_cnt_now;
            r_arrived <= w_arr_now;
            r_arr_cnt <= w_arr_cnt;
            if (w_lock) begin
              r_offset <= w_new_off;
              if (packet_done) begin
                r_state    <= ST_FLUSH;
                r_word_vld <= 1'b0;
              end else begin
                r_state    <= ST_LOCKED;
                r_word_vld <= 1'b1;
              end
            end else if (w_fail) begin
              r_invalid <= 1'b1;
              r_state   <= ST_FLUSH;
            end else begin
              r_state <= ST_ALIGN;
            end
          end
        end
        ST_LOCKED: begin
          if (packet_done) begin
            r_word_vld <= 1'b0;
            r_state    <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (lane_byte_vld == '0) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_delay_line #(
      .DEPTH(MAX_SKEW + 1)
    ) u_dl (
      .clk   (clk),
      .resetn(resetn),
      .i_data(lane_byte_data[g*8 +: 8]),
      .i_tap (w_tap[g*OFFSET_W +: OFFSET_W]),
      .o_data(w_lane_out[g*8 +: 8])
    );
  end

  // Aligned word register, refreshed every cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_word <= '0;
    end else begin
      r_word <= w_lane_out;
    end
  end

  assign word_data     = r_word;
  assign word_vld      = r_word_vld;
  assign invalid_start = r_invalid;
  assign lane_offset   = r_offset;

endmodule

// File: tb/tb_lane_deskew.sv
// Directed bench for lane_deskew: a 4-lane vector table plus 2-lane sequences.
module tb_lane_deskew;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pd = 1'b0;

  logic [1:0]  v2 = '0;
  logic [15:0] d2 = '0;
  logic [15:0] wd2;
  logic        wv2, inv2;
  logic [5:0]  off2;

  logic [3:0]  v4 = '0;
  logic [31:0] d4 = '0;
  logic [31:0] wd4;
  logic        wv4, inv4;
  logic [11:0] off4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        pd;
    logic        e_vld;
    logic        e_inv;
    logic        chk_d;
    logic [31:0] e_d;
    logic [11:0] e_off;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  lane_deskew #(.NUM_LANES(2), .MAX_SKEW(3)) dut2 (
    .clk(clk), .resetn(resetn), .lane_byte_data(d2), .lane_byte_vld(v2),
    .packet_done(pd), .word_data(wd2), .word_vld(wv2),
    .invalid_start(inv2), .lane_offset(off2)
  );

  lane_deskew #(.NUM_LANES(4), .MAX_SKEW(3)) dut4 (
    .clk(clk), .resetn(resetn), .lane_byte_data(d4), .lane_byte_vld(v4),
    .packet_done(pd), .word_data(wd4), .word_vld(wv4),
    .invalid_start(inv4), .lane_offset(off4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic step(input logic [1:0] a_v2, input logic [15:0] a_d2,
                      input logic [3:0] a_v4, input logic [31:0] a_d4, input logic a_pd);
    v2 = a_v2; d2 = a_d2; v4 = a_v4; d4 = a_d4; pd = a_pd;
    @(posedge clk);
    #1;
  endtask

  task automatic s2(input logic [1:0] a_v, input logic [15:0] a_d, input logic a_pd);
    step(a_v, a_d, 4'h0, 32'h0, a_pd);
  endtask

  initial begin
    //          v     d             pd    vld   inv   chk   e_d           e_off
    vecs[0]  = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 12'h000};
    vecs[1]  = '{4'h1, 32'h000000A0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 12'h000};
    vecs[2]  = '{4'h5, 32'h00A200A4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 12'h000};
    vecs[3]  = '{4'h7, 32'h00A6A1A8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 12'h000};
    vecs[4]  = '{4'hF, 32'hA3AAA5AC, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA3A2A1A0, 12'h08B};
    vecs[5]  = '{4'hF, 32'hA7AEA9B0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA7A6A5A4, 12'h08B};
    vecs[6]  = '{4'hE, 32'hABB2AD00, 1'b0, 1'b1, 1'b0, 1'b1, 32'hABAAA9A8, 12'h08B};
    vecs[7]  = '{4'hF, 32'hAFB6B1B8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 12'h08B};
    vecs[8]  = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 12'h08B};
    vecs[9]  = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 12'h08B};
    vecs[10] = '{4'hF, 32'h04030201, 1'b0, 1'b1, 1'b0, 1'b1, 32'h04030201, 12'h000};
    vecs[11] = '{4'hF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 12'h000};
    vecs[12] = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 12'h000};

    // Reset state of both instances.
    resetn = 1'b0;
    s2(2'b00, 16'h0, 1'b0);
    s2(2'b00, 16'h0, 1'b0);
    chk("rst2_data", wd2, 0);  chk("rst2_vld", wv2, 0);
    chk("rst2_inv", inv2, 0);  chk("rst2_off", off2, 0);
    chk("rst4_data", wd4, 0);  chk("rst4_vld", wv4, 0);
    chk("rst4_inv", inv4, 0);  chk("rst4_off", off4, 0);
    resetn = 1'b1;

    // 4-lane staggered arrival, lane drop while locked, relock at zero skew.
    for (int i = 0; i < 13; i++) begin
      step(2'b00, 16'h0, vecs[i].v, vecs[i].d, vecs[i].pd);
      chk($sformatf("tbl%0d_vld", i), wv4, vecs[i].e_vld);
      chk($sformatf("tbl%0d_inv", i), inv4, vecs[i].e_inv);
      chk($sformatf("tbl%0d_off", i), off4, vecs[i].e_off);
      if (vecs[i].chk_d) chk($sformatf("tbl%0d_data", i), wd4, vecs[i].e_d);
    end

    // 2-lane simultaneous start.
    s2(2'b11, 16'h2211, 1'b0);
    chk("sim_vld", wv2, 1); chk("sim_data", wd2, 32'h2211); chk("sim_off", off2, 0);
    chk("sim_inv", inv2, 0);
    s2(2'b11, 16'h4433, 1'b0);
    chk("sim_data2", wd2, 32'h4433);
    s2(2'b11, 16'h0000, 1'b1);
    chk("sim_done", wv2, 0);
    s2(2'b00, 16'h0, 1'b0);

    // Spread exactly MAX_SKEW: locks with lane0 delayed by 3.
    s2(2'b01, 16'h0010, 1'b0); chk("sk3_c0", wv2, 0);
    s2(2'b01, 16'h0011, 1'b0);
    s2(2'b01, 16'h0012, 1'b0); chk("sk3_c2", wv2, 0);
    s2(2'b11, 16'h2013, 1'b0);
    chk("sk3_vld", wv2, 1); chk("sk3_data", wd2, 32'h2010);
    chk("sk3_off", off2, 6'h03); chk("sk3_inv", inv2, 0);
    s2(2'b11, 16'h2114, 1'b0);
    chk("sk3_data2", wd2, 32'h2111);
    s2(2'b00, 16'h0, 1'b1);
    chk("sk3_done", wv2, 0);
    s2(2'b00, 16'h0, 1'b0);

    // Spread MAX_SKEW+1: alignment failure, FLUSH until all vld low.
    s2(2'b01, 16'h0001, 1'b0);
    for (int c = 1; c < 4; c++) begin
      s2(2'b01, 16'h0001, 1'b0);
      chk($sformatf("sk4_c%0d_inv", c), inv2, 0);
    end
    s2(2'b11, 16'h0101, 1'b0);
    chk("sk4_inv", inv2, 1); chk("sk4_vld", wv2, 0);
    chk("sk4_off_hold", off2, 6'h03);
    s2(2'b11, 16'h0101, 1'b0);
    chk("sk4_inv_once", inv2, 0); chk("sk4_vld1", wv2, 0);
    s2(2'b10, 16'h0100, 1'b0); chk("sk4_vld2", wv2, 0);
    s2(2'b11, 16'h0101, 1'b0); chk("sk4_flush_hold", wv2, 0);
    s2(2'b00, 16'h0, 1'b0);    chk("sk4_vld3", wv2, 0);
    s2(2'b11, 16'h5566, 1'b0);
    chk("sk4_relock", wv2, 1); chk("sk4_relock_data", wd2, 32'h5566);
    chk("sk4_relock_off", off2, 0);
    s2(2'b11, 16'h0, 1'b1);
    s2(2'b00, 16'h0, 1'b0);

    // 16-word burst, packet_done after the 16th word, relock 2 cycles later.
    for (int k = 0; k < 16; k++) begin
      s2(2'b11, {8'h80 + 8'(k), 8'(k)}, 1'b0);
      chk($sformatf("b16_w%0d_vld", k), wv2, 1);
      chk($sformatf("b16_w%0d_data", k), wd2, {16'h0, 8'h80 + 8'(k), 8'(k)});
    end
    s2(2'b11, 16'h0, 1'b1);
    chk("b16_done", wv2, 0);
    s2(2'b00, 16'h0, 1'b0); chk("b16_gap1", wv2, 0);
    s2(2'b00, 16'h0, 1'b0); chk("b16_gap2", wv2, 0);
    s2(2'b11, 16'h9988, 1'b0);
    chk("b16_relock", wv2, 1); chk("b16_relock_data", wd2, 32'h9988);
    s2(2'b11, 16'h0, 1'b1);
    s2(2'b00, 16'h0, 1'b0);

    // Reset pulse while locked with a nonzero offset.
    s2(2'b01, 16'h0030, 1'b0);
    s2(2'b01, 16'h0031, 1'b0);
    s2(2'b11, 16'h4032, 1'b0);
    chk("rp_lock_off", off2, 6'h02); chk("rp_lock_data", wd2, 32'h4030);
    s2(2'b11, 16'h4133, 1'b0);
    chk("rp_data2", wd2, 32'h4131);
    resetn = 1'b0;
    s2(2'b11, 16'h4234, 1'b0);
    chk("rp_data", wd2, 0); chk("rp_vld", wv2, 0);
    chk("rp_inv", inv2, 0); chk("rp_off", off2, 0);
    resetn = 1'b1;
    s2(2'b11, 16'h4335, 1'b0);
    chk("rp_relock_vld", wv2, 1); chk("rp_relock_off", off2, 0);
    chk("rp_relock_data", wd2, 32'h4335);
    s2(2'b11, 16'h0, 1'b1);
    s2(2'b00, 16'h0, 1'b0);

    // packet_done on the lock cycle: word_vld never rises, FSM in FLUSH.
    s2(2'b11, 16'h7777, 1'b1);
    chk("pdl_vld0", wv2, 0);
    s2(2'b11, 16'h7777, 1'b0);
    chk("pdl_vld1", wv2, 0);
    s2(2'b00, 16'h0, 1'b0);
    chk("pdl_vld2", wv2, 0);
    s2(2'b11, 16'h1234, 1'b0);
    chk("pdl_after", wv2, 1); chk("pdl_after_data", wd2, 32'h1234);
    s2(2'b00, 16'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
